// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and operand forwarding.
// Forwarding muxes exist only when ID_EX_FWD_EN is defined; otherwise ID stalls on RAW.
package riscv_lite_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLTU = 4'b1001
  } ALUControl_Enum;

endpackage

module id_ex_stage
  import riscv_lite_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST_n,
  input  logic            id_valid_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [XLEN-1:0] id_rs1_data_i,
  input  logic [XLEN-1:0] id_rs2_data_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic [4:0]      id_rs1_i,
  input  logic [4:0]      id_rs2_i,
  input  logic [4:0]      id_rd_i,
  input  ALUControl_Enum  id_alu_ctrl_i,
  input  logic            id_alu_src_i,
  input  logic            id_mem_read_i,
  input  logic            id_mem_write_i,
  input  logic            id_reg_write_i,
  input  logic            id_branch_i,
  input  logic            flush_i,
  input  logic [4:0]      exmem_rd_i,
  input  logic            exmem_reg_write_i,
  input  logic [XLEN-1:0] exmem_result_i,
  input  logic [4:0]      memwb_rd_i,
  input  logic            memwb_reg_write_i,
  input  logic [XLEN-1:0] memwb_result_i,
  output logic            stall_o,
  output logic            ex_valid_o,
  output logic [XLEN-1:0] ex_op1_o,
  output logic [XLEN-1:0] ex_op2_o,
  output ALUControl_Enum  ex_alu_ctrl_o,
  output logic [XLEN-1:0] ex_store_data_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [4:0]      ex_rd_o,
  output logic            ex_mem_read_o,
  output logic            ex_mem_write_o,
  output logic            ex_reg_write_o,
  output logic            ex_branch_o
);

  typedef struct packed {
    logic           valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]     rs1;
    logic [4:0]     rs2;
    logic [4:0]     rd;
    ALUControl_Enum alu_ctrl;
    logic           alu_src;
    logic           mem_read;
    logic           mem_write;
    logic           reg_write;
    logic           branch;
  } id_ex_t;

  id_ex_t ex_q, ex_d;

  logic hz;
  logic rs2_used;
  logic ex_rs1_hit, ex_rs2_hit;
  logic ld_use;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;

  always_comb begin
    rs2_used   = !id_alu_src_i | id_mem_write_i;
    ex_rs1_hit = (ex_q.rd != 5'd0) &
                 (ex_q.rd == id_rs1_i);
    ex_rs2_hit = (ex_q.rd != 5'd0) &
                 (ex_q.rd == id_rs2_i) &
                 rs2_used;
    ld_use     = ex_q.valid & ex_q.mem_read &
                 id_valid_i &
                 (ex_rs1_hit | ex_rs2_hit);
`ifdef ID_EX_FWD_EN
    hz = ld_use;
`else
    // Without bypass, any in-flight writer of a source must drain first
    hz = ld_use |
         (id_valid_i & ex_q.valid &
          ex_q.reg_write &
          (ex_rs1_hit | ex_rs2_hit)) |
         (id_valid_i & exmem_reg_write_i &
          (exmem_rd_i != 5'd0) &
          ((exmem_rd_i == id_rs1_i) |
           ((exmem_rd_i == id_rs2_i) &
            rs2_used)));
`endif
  end

  assign stall_o = hz & !flush_i & RST_n;

  always_comb begin
    ex_d.valid     = id_valid_i;
    ex_d.pc        = id_pc_i;
    ex_d.rs1_data  = id_rs1_data_i;
    ex_d.rs2_data  = id_rs2_data_i;
    ex_d.imm       = id_imm_i;
    ex_d.rs1       = id_rs1_i;
    ex_d.rs2       = id_rs2_i;
    ex_d.rd        = id_rd_i;
    ex_d.alu_ctrl  = id_alu_ctrl_i;
    ex_d.alu_src   = id_alu_src_i;
    ex_d.mem_read  = id_mem_read_i;
    ex_d.mem_write = id_mem_write_i;
    ex_d.reg_write = id_reg_write_i;
    ex_d.branch    = id_branch_i;
    if (flush_i | hz) begin
      ex_d          = '0;
      ex_d.alu_ctrl = ALU_ADD;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      ex_q          <= '0;
      ex_q.alu_ctrl <= ALU_ADD;
    end else begin
      ex_q <= ex_d;
    end
  end

`ifdef ID_EX_FWD_EN
  // EX/MEM is younger than MEM/WB, so it wins on a double match
  always_comb begin
    rs1_fwd = ex_q.rs1_data;
    if (exmem_reg_write_i &&
        exmem_rd_i != 5'd0 &&
        exmem_rd_i == ex_q.rs1)
      rs1_fwd = exmem_result_i;
    else if (memwb_reg_write_i &&
             memwb_rd_i != 5'd0 &&
             memwb_rd_i == ex_q.rs1)
      rs1_fwd = memwb_result_i;
  end

  always_comb begin
    rs2_fwd = ex_q.rs2_data;
    if (exmem_reg_write_i &&
        exmem_rd_i != 5'd0 &&
        exmem_rd_i == ex_q.rs2)
      rs2_fwd = exmem_result_i;
    else if (memwb_reg_write_i &&
             memwb_rd_i != 5'd0 &&
             memwb_rd_i == ex_q.rs2)
      rs2_fwd = memwb_result_i;
  end
`else
  logic unused_fwd;

  assign unused_fwd = ^{exmem_result_i,
                        memwb_rd_i,
                        memwb_reg_write_i,
                        memwb_result_i,
                        ex_q.rs1,
                        ex_q.rs2};

  always_comb begin
    rs1_fwd = ex_q.rs1_data;
    rs2_fwd = ex_q.rs2_data;
  end
`endif

  assign ex_valid_o      = ex_q.valid;
  assign ex_op1_o        = rs1_fwd;
  assign ex_op2_o        = ex_q.alu_src ? ex_q.imm
                                        : rs2_fwd;
  assign ex_alu_ctrl_o   = ex_q.alu_ctrl;
  assign ex_store_data_o = rs2_fwd;
  assign ex_pc_o         = ex_q.pc;
  assign ex_imm_o        = ex_q.imm;
  assign ex_rd_o         = ex_q.rd;
  assign ex_mem_read_o   = ex_q.mem_read;
  assign ex_mem_write_o  = ex_q.mem_write;
  assign ex_reg_write_o  = ex_q.reg_write;
  assign ex_branch_o     = ex_q.branch;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the RISCV-Lite core, sitting directly upstream of the `ALU`. It captures decoded operands and control from ID and resolves RAW hazards. It forwards results from EX/MEM and MEM/WB, detects load-use hazards, inserts bubbles, and handles branch flushes. It drives `ALU` `op1`/`op2`/`ALUControl` plus the control bits consumed by the EX/MEM register.

## Interface
- `XLEN`, 32, datapath width.
- `CLK` in 1: rising-edge clock.
- `RST_n` in 1: asynchronous active-low reset.
- `id_valid_i` in 1: ID holds a valid instruction.
- `id_pc_i`, `id_rs1_data_i`, `id_rs2_data_i`, `id_imm_i` in XLEN: PC, register-file reads, sign-extended immediate.
- `id_rs1_i`, `id_rs2_i`, `id_rd_i` in 5: register indices.
- `id_alu_ctrl_i` in `ALUControl_Enum`: ALU operation.
- `id_alu_src_i` in 1: 1 = op2 is the immediate.
- `id_mem_read_i`, `id_mem_write_i`, `id_reg_write_i`, `id_branch_i` in 1: control bits.
- `flush_i` in 1: branch taken in EX; kill the instruction in ID.
- `exmem_rd_i` in 5, `exmem_reg_write_i` in 1, `exmem_result_i` in XLEN: EX/MEM forwarding source.
- `memwb_rd_i` in 5, `memwb_reg_write_i` in 1, `memwb_result_i` in XLEN: MEM/WB forwarding source.
- `stall_o` out 1: hold PC and IF/ID this cycle.
- `ex_valid_o` out 1: EX holds a valid instruction.
- `ex_op1_o`, `ex_op2_o` out XLEN: to `ALU` `op1`/`op2`.
- `ex_alu_ctrl_o` out `ALUControl_Enum`: to `ALU` `ALUControl`.
- `ex_store_data_o` out XLEN: forwarded rs2 for stores.
- `ex_pc_o`, `ex_imm_o` out XLEN: to the branch-target adder.
- `ex_rd_o` out 5; `ex_mem_read_o`, `ex_mem_write_o`, `ex_reg_write_o`, `ex_branch_o` out 1.

## Operation
- Registered state:
  - Valid, PC, rs1/rs2 data, immediate, rs1/rs2/rd indices, alu_ctrl, alu_src, mem_read, mem_write, reg_write, branch.
- Bubble:
  - Valid, mem_read, mem_write, reg_write and branch = 0.
  - alu_ctrl = ADD; all indices and data = 0.
- Load-use hazard (combinational), `hz`:
  - `ex_valid_o & ex_mem_read_o & ex_rd_o!=0 & id_valid_i`, and
  - `ex_rd_o==id_rs1_i`, or `ex_rd_o==id_rs2_i` with `!id_alu_src_i | id_mem_write_i`.
- `stall_o = hz & !flush_i`.
- Register update priority each edge:
  1. `flush_i` → load bubble.
  2. Else `hz` → load bubble (ID holds via `stall_o`).
  3. Else load the ID fields; valid = `id_valid_i`.
- Forwarding for source s (rs1 or rs2), combinational on registered state:
  - EX/MEM when `exmem_reg_write_i & exmem_rd_i!=0 & exmem_rd_i==s`.
  - Else MEM/WB when `memwb_reg_write_i & memwb_rd_i!=0 & memwb_rd_i==s`.
  - Else the registered data.
  - EX/MEM wins when both match.
- ALU operands:
  - `ex_op1_o` = forwarded rs1.
  - `ex_op2_o` = immediate if alu_src, else forwarded rs2.
  - `ex_store_data_o` = forwarded rs2 always.
- x0 is never forwarded; a source index of 0 yields the registered data.

## Timing
- Reset (async, `RST_n`=0) loads a bubble immediately:
  - all outputs 0, except `ex_alu_ctrl_o`=ADD.
  - `ex_op1_o`/`ex_op2_o`/`ex_store_data_o` = 0 unless forwarding inputs match (indices are 0, so no match).
  - `stall_o` = 0.
- Latency: ID fields appear on `ex_*` one cycle after capture.
- Forwarded values follow their sources combinationally within the same cycle.
- A load-use hazard costs exactly one bubble. Next cycle the load is in EX/MEM; the dependent instruction re-presents and its forwarded value comes from MEM/WB as the load result reaches writeback.
- `flush_i` and `hz` together: bubble, `stall_o`=0, so IF/ID is refetched by the branch.
- Reset asserted mid-stall clears the stall within the same cycle.

## Configuration
- `ID_EX_FWD_EN` defined: forwarding as above; stalls only for load-use.
- Undefined: forwarding paths removed; operands come straight from registered data.
  - `hz` extends to any valid ID source (rs1 always; rs2 when used) equal to a nonzero `ex_rd_o` with `ex_reg_write_o`, or to `exmem_rd_i` with `exmem_reg_write_i`.
  - MEM/WB hazards are covered by the write-first register file.
  - Stalls repeat until clear (up to 2 cycles).
  - Flush priority is unchanged.

## Test plan
- Reset: `RST_n`=0 mid-run → `ex_valid_o`=0, `ex_reg_write_o`=0, `ex_alu_ctrl_o`=ADD, `stall_o`=0 immediately.
- EX/MEM forward: EX holds rs1=5, op ADD; `exmem_rd_i`=5, reg_write=1, result=0x0000_00AA; `memwb_rd_i`=5, result=0x11 → `ex_op1_o`=0xAA.
- Immediate select: alu_src=1, imm=0xFFFF_FFF0, rs2 forwarded 0x1234 → `ex_op2_o`=0xFFFF_FFF0, `ex_store_data_o`=0x1234.
- Load-use: EX holds lw x7; ID add x8,x7,x1 → `stall_o`=1 for one cycle, bubble in EX, then add enters EX with op1 forwarded from MEM/WB.
- Flush+hazard: same as previous case plus `flush_i`=1 → `stall_o`=0; EX gets a bubble next cycle.
- x0: `exmem_rd_i`=0, reg_write=1, result=0xDEAD; EX rs1=0, data 0 → `ex_op1_o`=0.
